// File: rtl/tdp_bram_arbiter_pkg.sv
// Shared helpers for the true-dual-port BRAM arbiter: pointer advance,
// the same-address hazard predicate and the owner-index width.
package tdp_arb_pkg;

    // Width of a requester index (NREQ is always >= 2, so this is >= 1)
    function automatic int idx_bits(input int nreq);
        return $clog2(nreq);
    endfunction

    // Round-robin advance: the requester after idx becomes highest priority
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned nreq);
        return (idx + 32'd1) % nreq;
    endfunction

    // Two accesses may not share a cycle when they hit the same address
    // and at least one of them writes; read/read to one address is safe.
    function automatic logic is_collision(
        input logic [31:0] addr_x,
        input logic [31:0] addr_y,
        input logic        we_x,
        input logic        we_y
    );
        return (addr_x == addr_y) && (we_x || we_y);
    endfunction

endpackage

// File: rtl/tdp_bram_arbiter_rr_pick.sv
// Round-robin picker: first requester at or after ptr that is valid and
// not excluded wins. Used once per RAM port.
module tdp_arb_rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IW-1:0]   ptr,
    input  logic [NREQ-1:0] exclude,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            found
);

    logic [IW-1:0] cand;

    // Walk the requesters in priority order and latch onto the first eligible one
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IW'((32'(ptr) + 32'(k)) % 32'(NREQ));
            if (!found && valid[cand] && !exclude[cand]) begin
                found       = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tdp_bram_arbiter.sv
// Shares both ports of a true-dual-port BRAM among NREQ requesters,
// round-robin, never co-issuing a same-address pair that includes a write.
// Read data is steered back to its owner two cycles after acceptance.
module tdp_bram_arbiter
    import tdp_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int ABITS = 10,
    parameter int DBITS = 16,
    parameter int CNTW  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        req_we,
    input  logic [NREQ*ABITS-1:0]  req_addr,
    input  logic [NREQ*DBITS-1:0]  req_wdata,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [NREQ*DBITS-1:0]  rsp_data,
    output logic [ABITS-1:0]       ram_a_addr,
    output logic [DBITS-1:0]       ram_a_wd,
    output logic                   ram_a_we,
    input  logic [DBITS-1:0]       ram_a_rd,
    output logic [ABITS-1:0]       ram_b_addr,
    output logic [DBITS-1:0]       ram_b_wd,
    output logic                   ram_b_we,
    input  logic [DBITS-1:0]       ram_b_rd,
    output logic [CNTW-1:0]        conflict_cnt
);

    localparam int IW = idx_bits(NREQ);

    logic [IW-1:0]         ptr_q, ptr_d;
    logic [CNTW-1:0]       cnt_q, cnt_d;
    logic                  own_a_vld_q, own_a_vld_d, own_b_vld_q, own_b_vld_d;
    logic [IW-1:0]         own_a_idx_q, own_a_idx_d, own_b_idx_q, own_b_idx_d;
    logic [NREQ-1:0]       rsp_valid_q, rsp_valid_d;
    logic [NREQ*DBITS-1:0] rsp_data_q, rsp_data_d;
    logic [ABITS-1:0]      a_addr_q, a_addr_d, b_addr_q, b_addr_d;
    logic [DBITS-1:0]      a_wd_q, a_wd_d, b_wd_q, b_wd_d;

    logic [NREQ-1:0]       eff_valid, grant_a, grant_b, coll, excl_b;
    logic [IW-1:0]         idx_a, idx_b;
    logic                  found_a, found_b, skip_any;
    logic [ABITS-1:0]      addr_a;
    int                    rel_i, rel_b;

    // Nothing is granted while in reset
    assign eff_valid = req_valid & {NREQ{~rst}};

    tdp_arb_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick_a (
        .valid   (eff_valid),
        .ptr     (ptr_q),
        .exclude ({NREQ{1'b0}}),
        .grant   (grant_a),
        .idx     (idx_a),
        .found   (found_a)
    );

    // Requesters that would hazard against port A's access are kept off port B
    always_comb begin
        addr_a = req_addr[idx_a*ABITS +: ABITS];
        coll   = '0;
        for (int i = 0; i < NREQ; i++) begin
            coll[i] = found_a && eff_valid[i] && !grant_a[i] &&
                      is_collision(32'(req_addr[i*ABITS +: ABITS]), 32'(addr_a),
                                   req_we[i], req_we[idx_a]);
        end
        excl_b = grant_a | coll;
    end

    tdp_arb_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick_b (
        .valid   (eff_valid),
        .ptr     (ptr_q),
        .exclude (excl_b),
        .grant   (grant_b),
        .idx     (idx_b),
        .found   (found_b)
    );

    assign req_ready = grant_a | grant_b;

    // A collider counts as skipped only if port B's scan passed over it
    always_comb begin
        skip_any = 1'b0;
        rel_i    = 0;
        rel_b    = (int'(idx_b) + NREQ - int'(ptr_q)) % NREQ;
        for (int i = 0; i < NREQ; i++) begin
            rel_i = (i + NREQ - int'(ptr_q)) % NREQ;
            if (coll[i] && (!found_b || rel_i < rel_b)) begin
                skip_any = 1'b1;
            end
        end
    end

    // RAM port drive; an idle port keeps its last address/data so it does not toggle
    always_comb begin
        a_addr_d = found_a ? req_addr[idx_a*ABITS +: ABITS]  : a_addr_q;
        a_wd_d   = found_a ? req_wdata[idx_a*DBITS +: DBITS] : a_wd_q;
        b_addr_d = found_b ? req_addr[idx_b*ABITS +: ABITS]  : b_addr_q;
        b_wd_d   = found_b ? req_wdata[idx_b*DBITS +: DBITS] : b_wd_q;
        ram_a_addr = a_addr_d;
        ram_a_wd   = a_wd_d;
        ram_a_we   = found_a && req_we[idx_a];
        ram_b_addr = b_addr_d;
        ram_b_wd   = b_wd_d;
        ram_b_we   = found_b && req_we[idx_b];
    end

    // Next-state: pointer, collision counter, read ownership and response steering
    always_comb begin
        ptr_d = ptr_q;
        if (found_b) begin
            ptr_d = IW'(rr_next(32'(idx_b), NREQ));
        end else if (found_a) begin
            ptr_d = IW'(rr_next(32'(idx_a), NREQ));
        end

        cnt_d = cnt_q;
        if (skip_any && (cnt_q != {CNTW{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end

        own_a_vld_d = found_a && !req_we[idx_a];
        own_a_idx_d = idx_a;
        own_b_vld_d = found_b && !req_we[idx_b];
        own_b_idx_d = idx_b;

        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (own_a_vld_q) begin
            rsp_valid_d[own_a_idx_q]                = 1'b1;
            rsp_data_d[own_a_idx_q*DBITS +: DBITS]  = ram_a_rd;
        end
        if (own_b_vld_q) begin
            rsp_valid_d[own_b_idx_q]                = 1'b1;
            rsp_data_d[own_b_idx_q*DBITS +: DBITS]  = ram_b_rd;
        end
    end

    // State registers; reset drops any reads still in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            cnt_q       <= '0;
            own_a_vld_q <= 1'b0;
            own_a_idx_q <= '0;
            own_b_vld_q <= 1'b0;
            own_b_idx_q <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            a_addr_q    <= '0;
            a_wd_q      <= '0;
            b_addr_q    <= '0;
            b_wd_q      <= '0;
        end else begin
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            own_a_vld_q <= own_a_vld_d;
            own_a_idx_q <= own_a_idx_d;
            own_b_vld_q <= own_b_vld_d;
            own_b_idx_q <= own_b_idx_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            a_addr_q    <= a_addr_d;
            a_wd_q      <= a_wd_d;
            b_addr_q    <= b_addr_d;
            b_wd_q      <= b_wd_d;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_tdp_bram_arbiter.sv
// Bench for tdp_bram_arbiter: behavioural BRAM, scan-list arbitration model,
// and a response scoreboard drained by an independent monitor.
module tb_tdp_bram_arbiter;

    localparam int NREQ  = 4;
    localparam int ABITS = 10;
    localparam int DBITS = 16;
    localparam int CNTW  = 4;
    localparam int DEPTH = 1 << ABITS;
    localparam int CMAX  = (1 << CNTW) - 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       req_we = '0;
    logic [NREQ*ABITS-1:0] req_addr = '0;
    logic [NREQ*DBITS-1:0] req_wdata = '0;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ*DBITS-1:0] rsp_data;
    logic [ABITS-1:0]      ram_a_addr, ram_b_addr;
    logic [DBITS-1:0]      ram_a_wd, ram_b_wd;
    logic                  ram_a_we, ram_b_we;
    logic [DBITS-1:0]      ram_a_rd, ram_b_rd;
    logic [CNTW-1:0]       conflict_cnt;

    tdp_bram_arbiter #(.NREQ(NREQ), .ABITS(ABITS), .DBITS(DBITS), .CNTW(CNTW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .ram_a_addr   (ram_a_addr),
        .ram_a_wd     (ram_a_wd),
        .ram_a_we     (ram_a_we),
        .ram_a_rd     (ram_a_rd),
        .ram_b_addr   (ram_b_addr),
        .ram_b_wd     (ram_b_wd),
        .ram_b_we     (ram_b_we),
        .ram_b_rd     (ram_b_rd),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural true-dual-port RAM with registered read; preloaded on the first edge
    logic [DBITS-1:0] ram [DEPTH];
    logic             ram_init = 1'b1;
    always @(posedge clk) begin
        if (ram_init) begin
            for (int k = 0; k < DEPTH; k++) ram[k] <= DBITS'(k * 37 + 5);
        end else begin
            ram_a_rd <= ram[ram_a_addr];
            ram_b_rd <= ram[ram_b_addr];
            if (ram_a_we) ram[ram_a_addr] <= ram_a_wd;
            if (ram_b_we) ram[ram_b_addr] <= ram_b_wd;
        end
    end

    // Reference model state
    typedef struct {
        int               req;
        int               due;
        logic [DBITS-1:0] data;
    } exp_t;

    exp_t             expq[$];
    logic [DBITS-1:0] ref_mem [DEPTH];
    int               m_ptr = 0;
    int               m_cnt = 0;
    int               vectors = 0;
    int               miscompares = 0;
    bit               done = 1'b0;

    // Stimulus for the next cycle
    logic [NREQ-1:0]  sv, sw;
    logic [ABITS-1:0] sa [NREQ];
    logic [DBITS-1:0] sd [NREQ];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic clearStim();
        sv = '0;
        sw = '0;
        for (int i = 0; i < NREQ; i++) begin
            sa[i] = '0;
            sd[i] = '0;
        end
    endtask

    // Build the priority list from the pointer; A takes the head, B the first
    // later entry that does not hazard against A.
    task automatic modelArbitrate(output int ga, output int gb, output bit skipped);
        int order[$];
        int c;
        ga = -1;
        gb = -1;
        skipped = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            c = (m_ptr + k) % NREQ;
            if (sv[c]) order.push_back(c);
        end
        if (order.size() > 0) begin
            ga = order.pop_front();
            while (order.size() > 0 && gb < 0) begin
                c = order.pop_front();
                if (sa[c] == sa[ga] && (sw[c] || sw[ga])) skipped = 1'b1;
                else gb = c;
            end
        end
    endtask

    task automatic checkOutput(input int ga, input int gb);
        logic [NREQ-1:0] exp_ready;
        exp_ready = '0;
        if (ga >= 0) exp_ready[ga] = 1'b1;
        if (gb >= 0) exp_ready[gb] = 1'b1;
        cmp("req_ready", 32'(req_ready), 32'(exp_ready));
        cmp("ram_a_we", 32'(ram_a_we), (ga >= 0) ? 32'(sw[ga]) : 32'd0);
        cmp("ram_b_we", 32'(ram_b_we), (gb >= 0) ? 32'(sw[gb]) : 32'd0);
        cmp("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
        if (ga >= 0) begin
            cmp("ram_a_addr", 32'(ram_a_addr), 32'(sa[ga]));
            if (sw[ga]) cmp("ram_a_wd", 32'(ram_a_wd), 32'(sd[ga]));
        end
        if (gb >= 0) begin
            cmp("ram_b_addr", 32'(ram_b_addr), 32'(sa[gb]));
            if (sw[gb]) cmp("ram_b_wd", 32'(ram_b_wd), 32'(sd[gb]));
        end
    endtask

    // One clock of stimulus: drive, predict, check at mid-cycle, advance the model
    task automatic applyStimulus(input bit r);
        int ga, gb;
        bit skipped;
        @(posedge clk);
        #1;
        ram_init  = 1'b0;
        rst       = r;
        req_valid = sv;
        req_we    = sw;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*ABITS +: ABITS]  = sa[i];
            req_wdata[i*DBITS +: DBITS] = sd[i];
        end
        ga = -1;
        gb = -1;
        skipped = 1'b0;
        if (!r) modelArbitrate(ga, gb, skipped);
        @(negedge clk);
        checkOutput(ga, gb);
        if (r) begin
            m_cnt = 0;
            m_ptr = 0;
            for (int k = expq.size() - 1; k >= 0; k--)
                if (expq[k].due >= cyc + 1) expq.delete(k);
        end else begin
            if (skipped && m_cnt < CMAX) m_cnt++;
            if (gb >= 0) m_ptr = (gb + 1) % NREQ;
            else if (ga >= 0) m_ptr = (ga + 1) % NREQ;
            if (ga >= 0 && !sw[ga]) expq.push_back('{ga, cyc + 2, ref_mem[sa[ga]]});
            if (gb >= 0 && !sw[gb]) expq.push_back('{gb, cyc + 2, ref_mem[sa[gb]]});
            if (ga >= 0 && sw[ga]) ref_mem[sa[ga]] = sd[ga];
            if (gb >= 0 && sw[gb]) ref_mem[sa[gb]] = sd[gb];
        end
    endtask

    // Monitor: every response pulse must match the oldest outstanding read of that requester
    always @(negedge clk) begin
        if (!done) begin
            for (int i = 0; i < NREQ; i++) begin
                if (rsp_valid[i] !== 1'b0) begin
                    int hit;
                    hit = -1;
                    for (int k = 0; k < expq.size(); k++)
                        if (expq[k].req == i && hit < 0) hit = k;
                    vectors++;
                    if (hit < 0) begin
                        miscompares++;
                        $display("[TB] FAIL rsp_spurious req%0d @cyc %0d: got pulse expected none", i, cyc);
                    end else begin
                        if (expq[hit].due != cyc || rsp_data[i*DBITS +: DBITS] !== expq[hit].data) begin
                            miscompares++;
                            $display("[TB] FAIL rsp_data req%0d @cyc %0d: got %0h expected %0h due cyc %0d",
                                     i, cyc, rsp_data[i*DBITS +: DBITS], expq[hit].data, expq[hit].due);
                        end
                        expq.delete(hit);
                    end
                end
            end
            for (int k = expq.size() - 1; k >= 0; k--) begin
                if (expq[k].due < cyc) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL rsp_missing req%0d @cyc %0d: got no pulse expected %0h", expq[k].req, cyc, expq[k].data);
                    expq.delete(k);
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = DBITS'(k * 37 + 5);
        clearStim();

        // Reset, then idle
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        for (int n = 0; n < 10; n++) applyStimulus(1'b0);

        // Write 0x12 to 0x0AB alongside a read of 0x012, then read back 0x0AB
        sv = 4'b0011; sw = 4'b0001;
        sa[0] = 10'h0AB; sd[0] = 16'h0012; sa[1] = 10'h012;
        applyStimulus(1'b0);
        clearStim();
        sv = 4'b0010; sa[1] = 10'h0AB;
        applyStimulus(1'b0);
        clearStim();
        for (int n = 0; n < 3; n++) applyStimulus(1'b0);

        // Write/read hazard on 0x005 from pointer 0
        applyStimulus(1'b1);
        sv = 4'b0011; sw = 4'b0001;
        sa[0] = 10'h005; sd[0] = 16'hBEEF; sa[1] = 10'h005;
        applyStimulus(1'b0);
        sv = 4'b0010; sw = 4'b0000;
        applyStimulus(1'b0);
        clearStim();
        for (int n = 0; n < 3; n++) applyStimulus(1'b0);

        // Read/read to the same address co-issues
        sv = 4'b1100; sa[2] = 10'h040; sa[3] = 10'h040;
        applyStimulus(1'b0);
        clearStim();
        for (int n = 0; n < 3; n++) applyStimulus(1'b0);

        // All four reading distinct addresses, held for four cycles
        applyStimulus(1'b1);
        sv = 4'b1111;
        for (int i = 0; i < NREQ; i++) sa[i] = ABITS'(10'h100 + i);
        for (int n = 0; n < 4; n++) applyStimulus(1'b0);
        clearStim();
        for (int n = 0; n < 3; n++) applyStimulus(1'b0);

        // Read in flight when reset hits
        sv = 4'b0001; sa[0] = 10'h033;
        applyStimulus(1'b0);
        clearStim();
        applyStimulus(1'b1);
        for (int n = 0; n < 4; n++) applyStimulus(1'b0);

        // Persistent hazard drives the counter into saturation
        sv = 4'b0011; sw = 4'b0001;
        sa[0] = 10'h009; sa[1] = 10'h009;
        for (int n = 0; n < 20; n++) begin
            sd[0] = DBITS'($urandom);
            applyStimulus(1'b0);
        end
        clearStim();
        for (int n = 0; n < 3; n++) applyStimulus(1'b0);
        applyStimulus(1'b1);

        // Randomized traffic on a small address window to provoke hazards
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                sv[i] = ($urandom_range(0, 99) < 65);
                sw[i] = ($urandom_range(0, 99) < 35);
                sa[i] = ABITS'($urandom_range(0, 7));
                sd[i] = DBITS'($urandom);
            end
            applyStimulus($urandom_range(0, 99) == 0);
        end
        clearStim();
        for (int n = 0; n < 5; n++) applyStimulus(1'b0);

        cmp("rsp_outstanding", 32'(expq.size()), 32'd0);
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
